// File: rtl/if_fetch_stage_if.sv
// Instruction-side SRAM-like port: a request handshake (req/addr_ok) followed by one data return (data_ok).
interface if_fetch_stage_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (output inst_req, inst_addr, input inst_addr_ok, inst_data_ok, inst_rdata);
    modport slave  (input inst_req, inst_addr, output inst_addr_ok, inst_data_ok, inst_rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS IF stage: one outstanding fetch, one-entry IF buffer, and the valid/allowin producer towards ID.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ID_allowin,
    input  logic             ID_PCSrc,
    input  logic [31:0]      ID_PCBranch,
    if_fetch_stage_if.master inst,
    output logic             IF_to_ID_valid,
    output logic [31:0]      PC,
    output logic [31:0]      next_PC,
    output logic [31:0]      ins_reg,
    output logic             IF_adef
);
    typedef enum logic [1:0] {REQ, WAIT, HOLD} state_t;

    state_t      state, state_nxt;
    logic        br_pending;
    logic [31:0] br_target;
    logic [31:0] fetch_target;
    logic        misaligned;
    logic        handoff;
    logic        br_leave;

    assign misaligned     = |PC[1:0];
    assign handoff        = IF_to_ID_valid & ID_allowin;
    assign br_leave       = ID_PCSrc & ID_allowin;
    assign next_PC        = PC + 32'd4;
    assign inst.inst_addr = PC;

    // The buffer always holds the delay slot of whatever branch sits in ID, so a
    // redirect is applied on the handoff that follows it; a live branch beats a captured one.
    always_comb begin
        if (br_leave)        fetch_target = ID_PCBranch;
        else if (br_pending) fetch_target = br_target;
        else                 fetch_target = next_PC;
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= REQ;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        inst.inst_req  = 1'b0;
        IF_to_ID_valid = 1'b0;
        case (state)
            REQ: begin
                if (misaligned) begin
                    state_nxt = HOLD;
                end else begin
                    inst.inst_req = 1'b1;
                    if (inst.inst_addr_ok) state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (inst.inst_data_ok) state_nxt = HOLD;
            end
            HOLD: begin
                IF_to_ID_valid = 1'b1;
                if (ID_allowin) state_nxt = REQ;
            end
            default: state_nxt = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            PC         <= RESET_PC;
            ins_reg    <= 32'd0;
            IF_adef    <= 1'b0;
            br_pending <= 1'b0;
            br_target  <= 32'd0;
        end else begin
            // A misaligned PC never reaches memory; it becomes a bubble-free adef entry.
            if (state == REQ && misaligned) begin
                ins_reg <= 32'd0;
                IF_adef <= 1'b1;
            end
            if (state == WAIT && inst.inst_data_ok) begin
                ins_reg <= inst.inst_rdata;
                IF_adef <= 1'b0;
            end
            if (handoff) PC <= fetch_target;
            if (br_leave && !handoff) begin
                br_pending <= 1'b1;
                br_target  <= ID_PCBranch;
            end else if (handoff) begin
                br_pending <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: randomized memory/ID behaviour against a delivered-PC-stream reference model.
module tb_if_fetch_stage;
    localparam logic [31:0] RST = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ID_allowin, ID_PCSrc;
    logic [31:0] ID_PCBranch;
    logic        IF_to_ID_valid, IF_adef;
    logic [31:0] PC, next_PC, ins_reg;

    if_fetch_stage_if ifc();

    if_fetch_stage #(.RESET_PC(RST)) dut (
        .clk(clk), .resetn(resetn), .ID_allowin(ID_allowin), .ID_PCSrc(ID_PCSrc),
        .ID_PCBranch(ID_PCBranch), .inst(ifc), .IF_to_ID_valid(IF_to_ID_valid),
        .PC(PC), .next_PC(next_PC), .ins_reg(ins_reg), .IF_adef(IF_adef)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ho, vld, req, adef, e_adef;
        logic [31:0] addr, pc, npc, ins, e_pc, e_ins;
    } obs_t;

    int errors = 0, checks = 0;
    // stimulus knobs
    int p_allow, p_branch, p_addr, p_spur, dlat_min, dlat_max, dmode, stall_cnt;
    logic [31:0] br_at, br_tgt;
    bit done_br;
    // memory model
    bit mem_busy;
    int mem_cnt;
    logic [31:0] mem_addr;
    // reference model: next PC ID must receive, plus a redirect owed after the delay slot
    logic [31:0] exp_pc, id_pc, rd_target;
    bit rd_valid, id_valid, id_ds;
    int proto_viol, bad_req, n_ho;
    bit last_stuck;
    logic [31:0] last_addr;
    logic [31:0] req_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5EEDC0DE;
    endfunction

    function automatic logic [31:0] rand_tgt();
        logic [31:0] t;
        t = RST | (32'($urandom_range(0, 4095)) << 2);
        if ($urandom_range(0, 99) < 5) t = t + 32'd2;
        return t;
    endfunction

    task automatic model_reset();
        exp_pc = RST; rd_valid = 0; id_valid = 0; id_ds = 0; id_pc = 0; rd_target = 0;
        mem_busy = 0; mem_cnt = 0; mem_addr = 0; last_stuck = 0; last_addr = 0;
        proto_viol = 0; bad_req = 0; n_ho = 0; done_br = 0; stall_cnt = 0;
        req_log.delete();
    endtask

    task automatic set_knobs(input int pa, input int pb, input int pad, input int ps,
                             input int dmin, input int dmax, input int dm);
        p_allow = pa; p_branch = pb; p_addr = pad; p_spur = ps;
        dlat_min = dmin; dlat_max = dmax; dmode = dm;
    endtask

    task automatic hold_reset();
        resetn = 1'b0; ID_allowin = 1'b0; ID_PCSrc = 1'b0; ID_PCBranch = 32'd0;
        ifc.inst_addr_ok = 1'b0; ifc.inst_data_ok = 1'b0; ifc.inst_rdata = 32'd0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic start();
        hold_reset();
        resetn = 1'b1;
        model_reset();
    endtask

    // One clock: drive memory/ID for this cycle, observe, advance the model past the edge.
    task automatic tick(output obs_t o);
        logic allow, pcsrc, aok, dok;
        logic [31:0] tgt;
        aok = ifc.inst_req && ($urandom_range(0, 99) < p_addr);
        dok = mem_busy && mem_cnt == 0;
        ifc.inst_rdata = dok ? mem_word(mem_addr) : $urandom;
        if (!mem_busy && $urandom_range(0, 99) < p_spur) dok = 1'b1;
        allow = ($urandom_range(0, 99) < p_allow);
        pcsrc = 1'b0;
        tgt = $urandom;
        case (dmode)
            0: begin
                if (allow && id_valid && !id_ds && $urandom_range(0, 99) < p_branch) begin
                    pcsrc = 1'b1; tgt = rand_tgt();
                end else if (!allow && id_valid && $urandom_range(0, 99) < 30) begin
                    pcsrc = 1'b1;
                end
            end
            4: allow = 1'b0;
            default: begin
                allow = 1'b1;
                if (id_valid && id_pc == br_at && !done_br) begin
                    if (dmode == 1)      allow = IF_to_ID_valid;
                    else if (dmode == 2) allow = mem_busy;
                    else begin allow = (stall_cnt >= 3); pcsrc = 1'b1; stall_cnt++; end
                    if (allow) begin pcsrc = 1'b1; tgt = br_tgt; done_br = 1; end
                end
            end
        endcase
        ifc.inst_addr_ok = aok; ifc.inst_data_ok = dok;
        ID_allowin = allow; ID_PCSrc = pcsrc; ID_PCBranch = tgt;
        #1;
        o.vld = IF_to_ID_valid; o.ho = IF_to_ID_valid && allow;
        o.req = ifc.inst_req; o.addr = ifc.inst_addr;
        o.pc = PC; o.npc = next_PC; o.ins = ins_reg; o.adef = IF_adef;
        o.e_pc = exp_pc; o.e_adef = (exp_pc[1:0] != 2'b00);
        o.e_ins = o.e_adef ? 32'd0 : mem_word(exp_pc);
        if (last_stuck && (!o.req || o.addr !== last_addr)) proto_viol++;
        if (o.req && mem_busy) proto_viol++;
        if (o.req && o.addr[1:0] != 2'b00) bad_req++;
        last_stuck = o.req && !aok;
        last_addr = o.addr;
        if (o.req && aok) begin
            req_log.push_back(o.addr);
            mem_busy = 1; mem_addr = o.addr; mem_cnt = $urandom_range(dlat_max, dlat_min);
        end else if (mem_busy) begin
            if (mem_cnt == 0) mem_busy = 0;
            else mem_cnt--;
        end
        if (allow && pcsrc) begin rd_valid = 1; rd_target = tgt; id_valid = 0; end
        if (o.ho) begin
            n_ho++; id_valid = 1; id_pc = exp_pc; id_ds = rd_valid;
            if (rd_valid) begin exp_pc = rd_target; rd_valid = 0; end
            else exp_pc = exp_pc + 32'd4;
        end else if (allow) begin
            id_valid = 0;
        end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset();
        hold_reset();
        hold_reset();
        checks++; if (IF_to_ID_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", IF_to_ID_valid); end
        checks++; if (PC !== RST) begin errors++; $display("FAIL reset_pc: got %h want %h", PC, RST); end
        checks++; if (next_PC !== RST + 32'd4) begin errors++; $display("FAIL reset_next_pc: got %h want %h", next_PC, RST + 32'd4); end
        checks++; if (ins_reg !== 32'd0) begin errors++; $display("FAIL reset_ins: got %h want 0", ins_reg); end
        checks++; if (IF_adef !== 1'b0) begin errors++; $display("FAIL reset_adef: got %b want 0", IF_adef); end
        resetn = 1'b1;
        model_reset();
        #1;
        checks++;
        if (ifc.inst_req !== 1'b1 || ifc.inst_addr !== RST) begin
            errors++; $display("FAIL reset_first_req: req=%b addr=%h want req=1 addr=%h", ifc.inst_req, ifc.inst_addr, RST);
        end
    endtask

    task automatic test_sequential();
        obs_t o;
        start();
        set_knobs(100, 0, 100, 0, 0, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            tick(o);
            checks++;
            if (o.ho !== ((k % 3) == 0)) begin errors++; $display("FAIL seq_timing: cycle %0d handoff=%b want %b", k, o.ho, (k % 3) == 0); end
            if (o.ho) begin
                checks++;
                if (o.pc !== o.e_pc || o.npc !== o.e_pc + 32'd4 || o.ins !== o.e_ins || o.adef !== o.e_adef) begin
                    errors++; $display("FAIL seq_handoff: pc=%h npc=%h ins=%h adef=%b want pc=%h ins=%h adef=%b", o.pc, o.npc, o.ins, o.adef, o.e_pc, o.e_ins, o.e_adef);
                end
            end
        end
    endtask

    task automatic test_stall();
        obs_t o;
        bit found;
        logic [31:0] pc0, ins0;
        start();
        set_knobs(0, 0, 100, 100, 0, 0, 4);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            tick(o);
            if (o.vld) begin found = 1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL stall_reach_hold: valid never rose within 20 cycles"); end
        pc0 = o.pc; ins0 = o.ins;
        checks++;
        if (pc0 !== RST || ins0 !== mem_word(RST)) begin errors++; $display("FAIL stall_first_entry: pc=%h ins=%h want pc=%h ins=%h", pc0, ins0, RST, mem_word(RST)); end
        for (int i = 0; i < 5; i++) begin
            tick(o);
            checks++;
            if (o.vld !== 1'b1 || o.pc !== pc0 || o.ins !== ins0 || o.req !== 1'b0) begin
                errors++; $display("FAIL stall_hold: vld=%b pc=%h ins=%h req=%b want vld=1 pc=%h ins=%h req=0", o.vld, o.pc, o.ins, o.req, pc0, ins0);
            end
        end
        set_knobs(100, 0, 100, 0, 0, 0, 0);
        tick(o);
        checks++;
        if (o.ho !== 1'b1 || o.pc !== o.e_pc || o.ins !== o.e_ins) begin
            errors++; $display("FAIL stall_release: ho=%b pc=%h ins=%h want ho=1 pc=%h ins=%h", o.ho, o.pc, o.ins, o.e_pc, o.e_ins);
        end
    endtask

    // mode 1: branch leaves with the delay slot handoff; 2: while the slot is in WAIT; 3: after 3 stalled PCSrc cycles
    task automatic test_branch_redirect(input int mode);
        obs_t o;
        int dl, idx;
        dl = (mode == 2) ? 4 : (mode == 3) ? 5 : 0;
        start();
        set_knobs(100, 0, 100, 0, dl, dl, mode);
        br_at = RST + 32'h10; br_tgt = RST + 32'h100;
        for (int i = 0; i < 150 && n_ho < 8; i++) begin
            tick(o);
            if (o.ho) begin
                checks++;
                if (o.pc !== o.e_pc || o.npc !== o.e_pc + 32'd4 || o.ins !== o.e_ins || o.adef !== o.e_adef) begin
                    errors++; $display("FAIL branch%0d_handoff: pc=%h npc=%h ins=%h adef=%b want pc=%h ins=%h adef=%b", mode, o.pc, o.npc, o.ins, o.adef, o.e_pc, o.e_ins, o.e_adef);
                end
            end
        end
        checks++; if (n_ho < 8 || !done_br) begin errors++; $display("FAIL branch%0d_progress: handoffs=%0d taken=%0d want 8 and 1", mode, n_ho, done_br); end
        idx = -1;
        foreach (req_log[i]) if (req_log[i] == RST + 32'h14 && idx < 0) idx = i;
        checks++;
        if (idx < 0 || idx + 1 >= req_log.size() || req_log[idx + 1] !== RST + 32'h100) begin
            errors++; $display("FAIL branch%0d_fetch_after_slot: slot_index=%0d log_size=%0d want fetch %h after %h", mode, idx, req_log.size(), RST + 32'h100, RST + 32'h14);
        end
        foreach (req_log[i]) begin
            checks++;
            if (req_log[i] === RST + 32'h18) begin errors++; $display("FAIL branch%0d_no_fallthrough: fetched %h", mode, req_log[i]); end
        end
        checks++; if (proto_viol != 0) begin errors++; $display("FAIL branch%0d_protocol: violations=%0d want 0", mode, proto_viol); end
    endtask

    task automatic test_adef();
        obs_t o;
        int n_adef;
        start();
        set_knobs(100, 0, 100, 0, 0, 0, 1);
        br_at = RST + 32'h8; br_tgt = 32'h00400002;
        n_adef = 0;
        for (int i = 0; i < 60 && n_ho < 6; i++) begin
            tick(o);
            if (o.ho) begin
                if (o.adef) n_adef++;
                checks++;
                if (o.pc !== o.e_pc || o.npc !== o.e_pc + 32'd4 || o.ins !== o.e_ins || o.adef !== o.e_adef) begin
                    errors++; $display("FAIL adef_handoff: pc=%h npc=%h ins=%h adef=%b want pc=%h ins=%h adef=%b", o.pc, o.npc, o.ins, o.adef, o.e_pc, o.e_ins, o.e_adef);
                end
            end
        end
        checks++; if (n_ho != 6 || n_adef != 2) begin errors++; $display("FAIL adef_count: handoffs=%0d adef=%0d want 6 and 2", n_ho, n_adef); end
        checks++; if (bad_req != 0) begin errors++; $display("FAIL adef_no_request: misaligned requests=%0d want 0", bad_req); end
    endtask

    task automatic test_reset_mid_wait();
        obs_t o;
        start();
        set_knobs(100, 0, 100, 0, 4, 4, 2);
        br_at = RST + 32'h8; br_tgt = RST + 32'h200;
        for (int i = 0; i < 60 && !done_br; i++) tick(o);
        checks++; if (!done_br || !mem_busy) begin errors++; $display("FAIL rstwait_setup: taken=%0d waiting=%0d want 1 and 1", done_br, mem_busy); end
        hold_reset();
        #1;
        checks++;
        if (IF_to_ID_valid !== 1'b0 || PC !== RST || ifc.inst_req !== 1'b1 || ifc.inst_addr !== RST) begin
            errors++; $display("FAIL rstwait_state: vld=%b pc=%h req=%b addr=%h want vld=0 pc=%h req=1 addr=%h", IF_to_ID_valid, PC, ifc.inst_req, ifc.inst_addr, RST, RST);
        end
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        set_knobs(100, 0, 100, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            tick(o);
            if (o.ho) begin
                checks++;
                if (o.pc !== o.e_pc || o.ins !== o.e_ins || o.adef !== o.e_adef) begin
                    errors++; $display("FAIL rstwait_handoff: pc=%h ins=%h adef=%b want pc=%h ins=%h adef=%b", o.pc, o.ins, o.adef, o.e_pc, o.e_ins, o.e_adef);
                end
            end
        end
        checks++; if (n_ho != 3) begin errors++; $display("FAIL rstwait_count: handoffs=%0d want 3", n_ho); end
    endtask

    task automatic test_random();
        obs_t o;
        start();
        set_knobs(70, 25, 60, 20, 0, 3, 0);
        for (int i = 0; i < 3000; i++) begin
            tick(o);
            if (o.ho) begin
                checks++;
                if (o.pc !== o.e_pc || o.npc !== o.e_pc + 32'd4 || o.ins !== o.e_ins || o.adef !== o.e_adef) begin
                    errors++; $display("FAIL rand_handoff: pc=%h npc=%h ins=%h adef=%b want pc=%h ins=%h adef=%b", o.pc, o.npc, o.ins, o.adef, o.e_pc, o.e_ins, o.e_adef);
                end
            end
        end
        checks++; if (proto_viol != 0) begin errors++; $display("FAIL rand_protocol: violations=%0d want 0", proto_viol); end
        checks++; if (bad_req != 0) begin errors++; $display("FAIL rand_misaligned_req: count=%0d want 0", bad_req); end
        checks++; if (n_ho < 200) begin errors++; $display("FAIL rand_progress: handoffs=%0d want >=200", n_ho); end
    endtask

    initial begin
        set_knobs(100, 0, 100, 0, 0, 0, 0);
        br_at = 32'd0; br_tgt = 32'd0;
        model_reset();
        test_reset();
        test_sequential();
        test_stall();
        test_branch_redirect(1);
        test_branch_redirect(2);
        test_branch_redirect(3);
        test_adef();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
